seven_seg_scan_pio: RTL and testbench
=====================================

SEVEN_SEG_SCAN_PIO -- requirements
Module: seven_seg_scan_pio

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit is driven; legal range >= 2.
REQ-003 Parameter BLINK_FRAMES, default 25, full scan frames per blink half-period; legal range >= 1.
REQ-004 clk  in  1  single clock; all state SHALL be clocked on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  2  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  combinational read data for the current address; unused bits 0.
REQ-011 seg_n  out  7  active-low segments, bit0 = a through bit6 = g.
REQ-012 dp_n  out  1  active-low decimal point.
REQ-013 digit_sel_n  out  DIGITS  active-low one-hot digit enable; bit i drives digit i.

Function
REQ-014 A write SHALL occur on a rising edge when chipselect=1 and write_n=0; all other cycles SHALL leave registers unchanged.
REQ-015 Address 0 DATA: bits [4*DIGITS-1:0] read/write; nibble i = hex value of digit i; upper bits ignored on write, read 0.
REQ-016 Address 1 CTRL: bit0 ENABLE, bit1 BLINK, bits [8+DIGITS-1:8] DP mask (bit 8+i lights DP of digit i); other bits ignored on write, read 0.
REQ-017 Address 2 SET: write SHALL do DATA <= DATA | writedata[4*DIGITS-1:0]; reads 0.
REQ-018 Address 3 CLEAR: write SHALL do DATA <= DATA & ~writedata[4*DIGITS-1:0]; reads 0.
REQ-019 Prescaler SHALL count 0..SCAN_DIV-1 while ENABLE=1; at SCAN_DIV-1 it SHALL wrap to 0 and advance digit index idx.
REQ-020 idx SHALL advance 0,1,...,DIGITS-1 and wrap to 0; each wrap to 0 ends one frame.
REQ-021 Frame counter SHALL count frames 0..BLINK_FRAMES-1; on wrap blink phase SHALL toggle.
REQ-022 While ENABLE=0, prescaler, idx, frame counter and blink phase SHALL be held at 0.
REQ-023 Writing ENABLE 1->0 mid-scan SHALL reset counters to 0 on the next edge; re-enable SHALL start at digit 0, full dwell.
REQ-024 seg_n, dp_n, digit_sel_n SHALL be registered, sampled every cycle from current DATA, CTRL, idx and blink phase: one-cycle latency.
REQ-025 Driven state: digit_sel_n = ~(1<<idx); seg_n = ~decode(DATA nibble idx); dp_n = ~DP mask bit idx.
REQ-026 decode (g..a, hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-027 Blank state (ENABLE=0, or BLINK=1 with blink phase=1): all outputs all-ones; counters continue when ENABLE=1.
REQ-028 With DIGITS=1, idx SHALL stay 0 and each prescaler wrap SHALL count one frame.

Reset
REQ-029 On reset assertion, asynchronously: DATA=0, CTRL=0, prescaler=0, idx=0, frame counter=0, blink phase=0, seg_n=7'h7F, dp_n=1, digit_sel_n all ones.
REQ-030 Writes during reset SHALL be ignored; operation SHALL resume on the first rising edge after deassertion.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset, then read addresses 0..3 -> readdata 0 each; outputs all ones.
REQ-032 Write DATA=32'h0000_3A10, CTRL=1 -> digit_sel_n 1110/1101/1011/0111 for 4 cycles each, seg_n 7'h40,7'h79,7'h08,7'h30, repeating every 16 cycles.
REQ-033 DATA=0, SET 32'h00F0 then CLEAR 32'h0030 -> DATA reads 32'h00C0; digit 1 shows seg_n 7'h46.
REQ-034 CTRL=32'h0000_0203 -> dp_n=0 only while digit 1 driven; outputs blank for 32 cycles after every 32 driven cycles.
REQ-035 Clear ENABLE during digit 2, re-enable -> outputs blank 1 cycle after clear; scan restarts digit 0 with full 4-cycle dwell.
REQ-036 Assert reset mid-frame with chipselect/write_n active -> outputs all ones immediately, DATA and CTRL read 0 after release.

Source files
------------

// File: rtl/seven_seg_scan_pio.sv
// Avalon-MM slave driving a multiplexed seven-segment display.
// DATA/CTRL registers with SET/CLEAR aliases, digit scan prescaler and frame-based blink.
module seven_seg_scan_pio #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [DIGITS-1:0] digit_sel_n
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLOTS  = 1 << IDX_W;

  logic [DATA_W-1:0] data_reg;
  logic              enable_reg;
  logic              blink_reg;
  logic [DIGITS-1:0] dp_mask_reg;
  logic [PRE_W-1:0]  presc_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [FRM_W-1:0]  frame_reg;
  logic              phase_reg;

  logic wr_en;
  logic presc_wrap;
  logic idx_wrap;
  logic frame_wrap;
  logic blank;
  logic unused_wd;

  assign wr_en      = chipselect & ~write_n;
  assign presc_wrap = (presc_reg == PRE_W'(SCAN_DIV - 1));
  assign idx_wrap   = (idx_reg == IDX_W'(DIGITS - 1));
  assign frame_wrap = (frame_reg == FRM_W'(BLINK_FRAMES - 1));
  assign blank      = ~enable_reg | (blink_reg & phase_reg);
  assign unused_wd  = ^writedata;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slots padded to a power of two so idx_reg can index without range issues.
  logic [6:0] pattern [SLOTS];
  logic       dp_slot [SLOTS];

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < DIGITS) begin : g_used
        assign pattern[gi] = decode(data_reg[4*gi +: 4]);
        assign dp_slot[gi] = dp_mask_reg[gi];
      end else begin : g_pad
        assign pattern[gi] = 7'h00;
        assign dp_slot[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg    <= '0;
      enable_reg  <= 1'b0;
      blink_reg   <= 1'b0;
      dp_mask_reg <= '0;
    end else if (wr_en) begin
      case (address)
        2'd0: data_reg <= writedata[DATA_W-1:0];
        2'd1: begin
          enable_reg  <= writedata[0];
          blink_reg   <= writedata[1];
          dp_mask_reg <= writedata[8 +: DIGITS];
        end
        2'd2: data_reg <= data_reg | writedata[DATA_W-1:0];
        default: data_reg <= data_reg & ~writedata[DATA_W-1:0];
      endcase
    end
  end

  // Counters follow the registered ENABLE, so a clear takes effect one edge after the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
      idx_reg   <= '0;
      frame_reg <= '0;
      phase_reg <= 1'b0;
    end else if (!enable_reg) begin
      presc_reg <= '0;
      idx_reg   <= '0;
      frame_reg <= '0;
      phase_reg <= 1'b0;
    end else if (presc_wrap) begin
      presc_reg <= '0;
      idx_reg   <= idx_wrap ? '0 : idx_reg + IDX_W'(1);
      if (idx_wrap) begin
        frame_reg <= frame_wrap ? '0 : frame_reg + FRM_W'(1);
        if (frame_wrap) begin
          phase_reg <= ~phase_reg;
        end
      end
    end else begin
      presc_reg <= presc_reg + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      digit_sel_n <= '1;
    end else if (blank) begin
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      digit_sel_n <= '1;
    end else begin
      seg_n       <= ~pattern[idx_reg];
      dp_n        <= ~dp_slot[idx_reg];
      digit_sel_n <= ~(DIGITS'(1) << idx_reg);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[DATA_W-1:0] = data_reg;
      2'd1: begin
        readdata[0]          = enable_reg;
        readdata[1]          = blink_reg;
        readdata[8 +: DIGITS] = dp_mask_reg;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_scan_pio.sv
// Bench for seven_seg_scan_pio: table-driven register checks, scan/blink/enable/reset
// sequences and random traffic against a cycle-count based reference model.
module tb_seven_seg_scan_pio;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  digit_sel_n;

  seven_seg_scan_pio #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_n(seg_n), .dp_n(dp_n), .digit_sel_n(digit_sel_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: register contents plus the number of enabled edges since enable.
  logic [15:0] m_data;
  logic        m_en;
  logic        m_blink;
  logic [3:0]  m_dp;
  int          m_n;
  logic [11:0] exp_out;

  logic [6:0] seg_rom [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] scan_seg [4] = '{7'h40, 7'h79, 7'h08, 7'h30};

  typedef struct {
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {16'h0, m_data};
      2'd1: return {16'h0, 4'h0, m_dp, 6'h0, m_blink, m_en};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [11:0] m_outs();
    int digit;
    int frames;
    logic phase;
    logic [3:0] nib;
    digit  = (m_n / SCAN_DIV) % DIGITS;
    frames = m_n / (SCAN_DIV * DIGITS);
    phase  = ((frames / BLINK_FRAMES) % 2) == 1;
    if (!m_en || (m_blink && phase)) return 12'hFFF;
    nib = m_data[4*digit +: 4];
    return {~seg_rom[nib], ~m_dp[digit], ~(4'b0001 << digit)};
  endfunction

  task automatic m_reset();
    m_data = '0; m_en = 1'b0; m_blink = 1'b0; m_dp = '0; m_n = 0; exp_out = 12'hFFF;
  endtask

  task automatic m_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_data = d[15:0];
      2'd1: begin m_en = d[0]; m_blink = d[1]; m_dp = d[11:8]; end
      2'd2: m_data = m_data | d[15:0];
      default: m_data = m_data & ~d[15:0];
    endcase
  endtask

  task automatic tick();
    logic [11:0] nxt;
    #1;
    check("readdata", readdata, m_read(address));
    nxt = m_outs();
    if (!reset) begin
      exp_out = nxt;
      m_n = m_en ? m_n + 1 : 0;
      if (chipselect && !write_n) m_write(address, writedata);
    end
    @(posedge clk);
    #1;
    check("outputs", {20'h0, seg_n, dp_n, digit_sel_n}, {20'h0, exp_out});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    int driven;
    int dp_low;
    int dp_bad;
    int first_blank;

    vecs[0] = '{2'd0, 32'h0000_3A10, 2'd0, 32'h0000_3A10};
    vecs[1] = '{2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_FFFF};
    vecs[2] = '{2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vecs[3] = '{2'd2, 32'h0000_00F0, 2'd0, 32'h0000_00F0};
    vecs[4] = '{2'd3, 32'h0000_0030, 2'd0, 32'h0000_00C0};
    vecs[5] = '{2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0F03};
    vecs[6] = '{2'd2, 32'h0000_1234, 2'd2, 32'h0000_0000};
    vecs[7] = '{2'd3, 32'h0000_0000, 2'd3, 32'h0000_0000};
    vecs[8] = '{2'd1, 32'h0000_0203, 2'd1, 32'h0000_0203};
    vecs[9] = '{2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000};

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    m_reset();
    repeat (3) tick();
    reset = 1'b0;

    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      check("reset_read", readdata, 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].wa, vecs[i].wd);
      address = vecs[i].ra;
      #1 check("table_read", readdata, vecs[i].exp);
      tick();
    end

    // Basic scan: digit order and decoded segments repeat every 16 cycles.
    wr(2'd0, 32'h0000_3A10);
    wr(2'd1, 32'h0000_0001);
    for (int k = 0; k < 32; k++) begin
      tick();
      check("scan_sel", {28'h0, digit_sel_n}, {28'h0, ~(4'b0001 << ((k / 4) % 4))});
      check("scan_seg", {25'h0, seg_n}, {25'h0, scan_seg[(k / 4) % 4]});
    end

    // SET then CLEAR.
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h0000_00F0);
    wr(2'd3, 32'h0000_0030);
    address = 2'd0;
    #1 check("set_clear", readdata, 32'h0000_00C0);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (digit_sel_n == 4'b1101) check("digit1_seg", {25'h0, seg_n}, 32'h46);
    end

    // Blink with DP on digit 1.
    wr(2'd1, 32'h0);
    tick();
    wr(2'd1, 32'h0000_0203);
    driven = 0; dp_low = 0; dp_bad = 0; first_blank = -1;
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (digit_sel_n != 4'hF) driven++;
      else if (first_blank < 0) first_blank = k;
      if (!dp_n) begin
        dp_low++;
        if (digit_sel_n != 4'b1101) dp_bad++;
      end
    end
    check("blink_driven", driven, 64);
    check("blink_first", first_blank, 33);
    check("dp_count", dp_low, 16);
    check("dp_digit", dp_bad, 0);

    // Disable during digit 2, then re-enable.
    wr(2'd1, 32'h0);
    tick();
    wr(2'd1, 32'h0000_0001);
    repeat (9) tick();
    check("pre_clear_sel", {28'h0, digit_sel_n}, 32'hB);
    wr(2'd1, 32'h0);
    check("clear_edge_sel", {28'h0, digit_sel_n}, 32'hB);
    tick();
    check("clear_blank", {20'h0, seg_n, dp_n, digit_sel_n}, 32'hFFF);
    tick();
    wr(2'd1, 32'h0000_0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("restart_dwell", {28'h0, digit_sel_n}, 32'hE);
    end
    tick();
    check("restart_next", {28'h0, digit_sel_n}, 32'hD);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      if (address == 2'd1) writedata[0] = ($urandom_range(0, 7) != 0);
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Asynchronous reset mid-frame with a write pending.
    wr(2'd0, 32'h0000_5678);
    wr(2'd1, 32'h0000_0F01);
    repeat (6) tick();
    #2;
    address = 2'd0; writedata = 32'hFFFF_FFFF; chipselect = 1'b1; write_n = 1'b0;
    reset = 1'b1;
    #1 check("async_reset_out", {20'h0, seg_n, dp_n, digit_sel_n}, 32'hFFF);
    m_reset();
    repeat (2) tick();
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0;
    #1 check("post_reset_data", readdata, 32'h0);
    address = 2'd1;
    #1 check("post_reset_ctrl", readdata, 32'h0);
    wr(2'd0, 32'h0000_0021);
    wr(2'd1, 32'h0000_0001);
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
